// File: rtl/aes128_host_seq.sv
// Host-side sequencer for an AES-128 core. Switches are loaded one nibble per button press into a plaintext block,
// the block is handed to the core, and the ciphertext is then shown one nibble per press on four LEDs.
module aes128_host_seq #(
  parameter int unsigned HOLD_CYCLES = 100_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   sw,
  input  logic         btn,
  input  logic         core_ready_i,
  output logic         core_start_o,
  output logic [127:0] core_pt_o,
  input  logic         core_done_i,
  input  logic [127:0] core_ct_i,
  output logic [3:0]   led,
  output logic         busy_o,
  output logic         done_o,
  output logic [1:0]   state_dbg,
  output logic [4:0]   idx_dbg
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_SHOW  = 2'd3
  } state_t;

  state_t         state, state_next;
  logic [1:0]     rst_pipe;
  logic           run;
  logic           btn_s1, btn_s2, btn_prev;
  logic           press;
  logic [4:0]     idx;
  logic [6:0]     bit_hi;
  logic [127:0]   pt, ct;
  logic [HW-1:0]  hold_cnt;
  logic           start_q, busy_q;
  logic           pt_we, pt_clr, idx_inc, idx_clr, capture, start_set;

  // Reset asserts asynchronously; the FSM is only released two edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign run = rst_pipe[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      btn_s1   <= btn;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end
  assign press = btn_s2 & ~btn_prev;

  assign bit_hi = 7'd127 - {idx, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_next;
  end

  // Core handshake: core_start_o is a single-cycle pulse issued only when core_ready_i was seen high in START;
  // core_done_i is a single-cycle strobe qualifying core_ct_i and is only honoured in WAIT.
  always_comb begin
    state_next = state;
    pt_we      = 1'b0;
    pt_clr     = 1'b0;
    idx_inc    = 1'b0;
    idx_clr    = 1'b0;
    capture    = 1'b0;
    start_set  = 1'b0;
    if (run) begin
      unique case (state)
        S_LOAD: begin
          if (press) begin
            pt_we = 1'b1;
            if (idx == 5'd31) begin
              idx_clr    = 1'b1;
              state_next = S_START;
            end else begin
              idx_inc = 1'b1;
            end
          end
        end
        S_START: begin
          if (core_ready_i) begin
            start_set  = 1'b1;
            state_next = S_WAIT;
          end
        end
        S_WAIT: begin
          if (core_done_i) begin
            capture    = 1'b1;
            idx_clr    = 1'b1;
            state_next = S_SHOW;
          end
        end
        S_SHOW: begin
          if (press) begin
            if (idx == 5'd31) begin
              pt_clr     = 1'b1;
              idx_clr    = 1'b1;
              state_next = S_LOAD;
            end else begin
              idx_inc = 1'b1;
            end
          end
        end
        default: state_next = S_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt       <= '0;
      ct       <= '0;
      idx      <= '0;
      hold_cnt <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (pt_clr)     pt <= '0;
      else if (pt_we) pt[bit_hi -: 4] <= sw;
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + 5'd1;
      if (capture) ct <= core_ct_i;
      // The hold counter runs regardless of state so a capture is always visible for the full hold time.
      if (capture)                hold_cnt <= HW'(HOLD_CYCLES);
      else if (hold_cnt != '0)    hold_cnt <= hold_cnt - 1'b1;
      start_q <= start_set;
      busy_q  <= (state_next == S_START) || (state_next == S_WAIT);
    end
  end

  assign core_start_o = start_q;
  assign busy_o       = busy_q;
  assign core_pt_o    = pt;
  assign done_o       = (hold_cnt != '0);
  assign led          = (state == S_SHOW) ? ct[bit_hi -: 4] : 4'h0;
  assign state_dbg    = state;
  assign idx_dbg      = idx;

endmodule

// File: tb/tb_aes128_host_seq.sv
// Directed bench for aes128_host_seq: three instances share all stimulus and differ only in HOLD_CYCLES (8, 1, 1000).
module tb_aes128_host_seq;

  localparam logic [1:0] ST_LOAD = 2'd0, ST_START = 2'd1, ST_WAIT = 2'd2, ST_SHOW = 2'd3;
  localparam logic [127:0] PT_UP = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] PT_DN = 128'hFEDCBA9876543210FEDCBA9876543210;
  localparam logic [127:0] CT1   = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
  localparam logic [127:0] CT2   = 128'h3925841D02DC09FBDC118597196A0B32;

  logic         clk, rst_n, btn, core_ready_i, core_done_i;
  logic [3:0]   sw;
  logic [127:0] core_ct_i;

  logic         core_start_o, busy_o, done_o;
  logic [127:0] core_pt_o;
  logic [3:0]   led;
  logic [1:0]   state_dbg;
  logic [4:0]   idx_dbg;

  logic         start_1, busy_1, done_1;
  logic [127:0] pt_1;
  logic [3:0]   led_1;
  logic [1:0]   state_1;
  logic [4:0]   idx_1;

  logic         start_l, busy_l, done_l;
  logic [127:0] pt_l;
  logic [3:0]   led_l;
  logic [1:0]   state_l;
  logic [4:0]   idx_l;

  int total = 0;
  int bad   = 0;

  aes128_host_seq #(.HOLD_CYCLES(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn), .core_ready_i(core_ready_i),
    .core_start_o(core_start_o), .core_pt_o(core_pt_o), .core_done_i(core_done_i), .core_ct_i(core_ct_i),
    .led(led), .busy_o(busy_o), .done_o(done_o), .state_dbg(state_dbg), .idx_dbg(idx_dbg)
  );

  aes128_host_seq #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn), .core_ready_i(core_ready_i),
    .core_start_o(start_1), .core_pt_o(pt_1), .core_done_i(core_done_i), .core_ct_i(core_ct_i),
    .led(led_1), .busy_o(busy_1), .done_o(done_1), .state_dbg(state_1), .idx_dbg(idx_1)
  );

  aes128_host_seq #(.HOLD_CYCLES(1000)) u_dutl (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn), .core_ready_i(core_ready_i),
    .core_start_o(start_l), .core_pt_o(pt_l), .core_done_i(core_done_i), .core_ct_i(core_ct_i),
    .led(led_l), .busy_o(busy_l), .done_o(done_l), .state_dbg(state_l), .idx_dbg(idx_l)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] v);
    sw  = v;
    btn = 1'b1;
    repeat (4) tick();
    btn = 1'b0;
    repeat (3) tick();
  endtask

  task automatic load_block(input bit down);
    for (int i = 0; i < 32; i++) press(down ? 4'(15 - (i % 16)) : 4'(i % 16));
  endtask

  task automatic pulse_done(input logic [127:0] v);
    core_ct_i   = v;
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic check_idle(input string tag);
    total++; if (state_dbg !== ST_LOAD) begin bad++; $display("FAIL %s_state got=%0d exp=%0d", tag, state_dbg, ST_LOAD); end
    total++; if (core_pt_o !== 128'h0) begin bad++; $display("FAIL %s_pt got=%h exp=0", tag, core_pt_o); end
    total++; if (led !== 4'h0) begin bad++; $display("FAIL %s_led got=%h exp=0", tag, led); end
    total++; if ({core_start_o, busy_o, done_o} !== 3'b000) begin bad++; $display("FAIL %s_flags got=%b exp=000", tag, {core_start_o, busy_o, done_o}); end
    total++; if (idx_dbg !== 5'd0) begin bad++; $display("FAIL %s_idx got=%0d exp=0", tag, idx_dbg); end
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check_idle("reset_async");
    total++; if ({done_1, done_l} !== 2'b00) begin bad++; $display("FAIL reset_done_other got=%b exp=00", {done_1, done_l}); end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check_idle("reset_release");
  endtask

  task automatic test_done_in_load();
    pulse_done(CT1);
    tick();
    check_idle("done_in_load");
  endtask

  task automatic test_load();
    press(4'h0);
    press(4'h1);
    total++; if (core_pt_o !== {8'h01, 120'h0}) begin bad++; $display("FAIL load_two got=%h exp=%h", core_pt_o, {8'h01, 120'h0}); end
    total++; if (idx_dbg !== 5'd2) begin bad++; $display("FAIL load_idx2 got=%0d exp=2", idx_dbg); end
    for (int i = 2; i < 31; i++) press(4'(i % 16));
    total++; if ({state_dbg, idx_dbg} !== {ST_LOAD, 5'd31}) begin bad++; $display("FAIL load_idx31 got=%0d/%0d exp=0/31", state_dbg, idx_dbg); end
    press(4'hF);
    total++; if (core_pt_o !== PT_UP) begin bad++; $display("FAIL load_pt got=%h exp=%h", core_pt_o, PT_UP); end
    total++; if (state_dbg !== ST_START) begin bad++; $display("FAIL load_state got=%0d exp=%0d", state_dbg, ST_START); end
    total++; if ({idx_dbg, busy_o, core_start_o} !== {5'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL load_idx_busy got=%0d/%b/%b exp=0/1/0", idx_dbg, busy_o, core_start_o); end
  endtask

  task automatic test_start_handshake();
    int pulses = 0;
    int stray  = 0;
    core_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (core_start_o || state_dbg !== ST_START || !busy_o) stray++;
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL start_hold got=%0d bad cycles exp=0", stray); end
    core_ready_i = 1'b1;
    tick();
    total++; if (core_start_o !== 1'b1) begin bad++; $display("FAIL start_first got=%b exp=1", core_start_o); end
    pulses = int'(core_start_o);
    for (int i = 0; i < 6; i++) begin
      tick();
      pulses += int'(core_start_o);
    end
    core_ready_i = 1'b0;
    total++; if (pulses !== 1) begin bad++; $display("FAIL start_pulses got=%0d exp=1", pulses); end
    total++; if ({state_dbg, busy_o} !== {ST_WAIT, 1'b1}) begin bad++; $display("FAIL start_wait got=%0d/%b exp=2/1", state_dbg, busy_o); end
  endtask

  task automatic test_ignored_in_wait();
    press(4'hF);
    press(4'hF);
    total++; if ({state_dbg, idx_dbg} !== {ST_WAIT, 5'd0}) begin bad++; $display("FAIL wait_press got=%0d/%0d exp=2/0", state_dbg, idx_dbg); end
    total++; if (core_pt_o !== PT_UP) begin bad++; $display("FAIL wait_pt got=%h exp=%h", core_pt_o, PT_UP); end
    total++; if ({done_o, led} !== 5'h0) begin bad++; $display("FAIL wait_done_led got=%b/%h exp=0/0", done_o, led); end
  endtask

  task automatic test_capture();
    int n8 = 0;
    int n1 = 0;
    pulse_done(CT1);
    total++; if ({state_dbg, busy_o} !== {ST_SHOW, 1'b0}) begin bad++; $display("FAIL cap_state got=%0d/%b exp=3/0", state_dbg, busy_o); end
    total++; if (led !== 4'h6) begin bad++; $display("FAIL cap_led0 got=%h exp=6", led); end
    for (int i = 0; i < 12; i++) begin
      n8 += int'(done_o);
      n1 += int'(done_1);
      tick();
    end
    total++; if (n8 !== 8) begin bad++; $display("FAIL hold8 got=%0d exp=8", n8); end
    total++; if (n1 !== 1) begin bad++; $display("FAIL hold1 got=%0d exp=1", n1); end
    total++; if (done_l !== 1'b1) begin bad++; $display("FAIL hold_long got=%b exp=1", done_l); end
    press(4'h0);
    total++; if ({led, idx_dbg} !== {4'h9, 5'd1}) begin bad++; $display("FAIL cap_led1 got=%h/%0d exp=9/1", led, idx_dbg); end
    pulse_done(CT2);
    tick();
    total++; if ({state_dbg, led, done_o} !== {ST_SHOW, 4'h9, 1'b0}) begin bad++; $display("FAIL show_done_ignored got=%0d/%h/%b exp=3/9/0", state_dbg, led, done_o); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 30; i++) press(4'h0);
    total++; if ({idx_dbg, led} !== {5'd31, 4'hA}) begin bad++; $display("FAIL wrap_last got=%0d/%h exp=31/a", idx_dbg, led); end
    press(4'h0);
    check_idle("wrap");
  endtask

  task automatic test_retrigger();
    int n = 0;
    load_block(1'b1);
    total++; if ({core_pt_o, state_dbg} !== {PT_DN, ST_START}) begin bad++; $display("FAIL retrig_pt got=%h/%0d exp=%h/1", core_pt_o, state_dbg, PT_DN); end
    core_ready_i = 1'b1;
    tick();
    core_ready_i = 1'b0;
    total++; if (done_l !== 1'b1) begin bad++; $display("FAIL retrig_before got=%b exp=1", done_l); end
    pulse_done(CT2);
    total++; if ({state_dbg, led} !== {ST_SHOW, 4'h3}) begin bad++; $display("FAIL retrig_show got=%0d/%h exp=3/3", state_dbg, led); end
    for (int i = 0; i < 1100; i++) begin
      if (!done_l) break;
      n++;
      tick();
    end
    total++; if (n !== 1000) begin bad++; $display("FAIL retrig_len got=%0d exp=1000", n); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    check_idle("reset_show");
    load_block(1'b0);
    core_ready_i = 1'b1;
    tick();
    core_ready_i = 1'b0;
    total++; if ({state_dbg, core_pt_o} !== {ST_WAIT, PT_UP}) begin bad++; $display("FAIL rw_wait got=%0d/%h exp=2/%h", state_dbg, core_pt_o, PT_UP); end
    rst_n = 1'b0;
    #1;
    check_idle("rw_async");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    pulse_done(CT1);
    tick();
    check_idle("rw_after_done");
    total++; if (done_l !== 1'b0) begin bad++; $display("FAIL rw_done_long got=%b exp=0", done_l); end
  endtask

  initial begin
    btn          = 1'b0;
    sw           = 4'h0;
    core_ready_i = 1'b0;
    core_done_i  = 1'b0;
    core_ct_i    = '0;
    test_reset();
    test_done_in_load();
    test_load();
    test_start_handshake();
    test_ignored_in_wait();
    test_capture();
    test_wrap();
    test_retrigger();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes128_host_seq.md
AES128_HOST_SEQ -- requirements
Module: aes128_host_seq

Interface
- REQ-001 Parameter HOLD_CYCLES, default 100_000_000; number of clk cycles done_o stays high after a result capture.
- REQ-002 clk  input  1  single clock; all state updates on the rising edge.
- REQ-003 rst_n  input  1  asynchronous, active-low reset.
- REQ-004 sw  input  4  nibble value to load; asynchronous to clk.
- REQ-005 btn  input  1  externally debounced push button; asynchronous to clk.
- REQ-006 core_ready_i  input  1  AES core idle and able to accept a block.
- REQ-007 core_start_o  output  1  one-cycle start pulse to the AES core.
- REQ-008 core_pt_o  output  128  plaintext block presented to the core.
- REQ-009 core_done_i  input  1  one-cycle pulse; core_ct_i is valid in the same cycle.
- REQ-010 core_ct_i  input  128  ciphertext from the core.
- REQ-011 led  output  4  selected ciphertext nibble; 4'h0 outside SHOW.
- REQ-012 busy_o  output  1  high in START and WAIT.
- REQ-013 done_o  output  1  result-latched indicator, stretched to HOLD_CYCLES.

Function
- REQ-014 btn SHALL pass through a 2-flop synchronizer; press = rising edge of the synchronized signal, one cycle wide.
- REQ-015 A press SHALL take effect on the 3rd rising clk edge after btn rises, given setup is met.
- REQ-016 FSM SHALL have 4 states: LOAD, START, WAIT, SHOW.
- REQ-017 LOAD, per press: write sw into pt[127-4*idx -: 4], then increment 5-bit idx (MSB nibble first).
- REQ-018 LOAD: the press that writes idx=31 SHALL wrap idx to 0 and move to START.
- REQ-019 START: core_start_o SHALL be high for exactly one cycle, in the first START cycle with core_ready_i=1, followed by a move to WAIT.
- REQ-020 START with core_ready_i=0: stay in START indefinitely, core_start_o=0.
- REQ-021 core_pt_o SHALL equal the pt register at all times and SHALL hold stable from START until the next LOAD write.
- REQ-022 WAIT, core_done_i=1: capture core_ct_i into ct, set idx=0, load hold counter with HOLD_CYCLES, move to SHOW.
- REQ-023 SHOW: led = ct[127-4*idx -: 4]; each press increments idx.
- REQ-024 SHOW: the press at idx=31 SHALL clear pt to 0 and idx to 0, and move to LOAD.
- REQ-025 Presses in START or WAIT SHALL be ignored.
- REQ-026 core_done_i outside WAIT SHALL be ignored.
- REQ-027 done_o SHALL be high while the hold counter is nonzero.
- REQ-028 The hold counter SHALL decrement once per cycle, saturate at 0, and be independent of state.
- REQ-029 A new capture while done_o is high SHALL reload the counter to HOLD_CYCLES.
- REQ-030 The hold counter width SHALL be $clog2(HOLD_CYCLES+1).
- REQ-031 HOLD_CYCLES=1 SHALL give a 1-cycle done_o.
- REQ-032 core_start_o and busy_o SHALL be registered outputs.
- REQ-033 led SHALL be registered or decoded from registered state only, with no combinational path from inputs.

Reset
- REQ-034 rst_n low SHALL immediately set: state LOAD, idx 0, pt 0, ct 0, hold counter 0, synchronizer flops 0, and outputs core_start_o=0, busy_o=0, done_o=0, led=0, core_pt_o=0.
- REQ-035 Reset asserted mid-operation (any state) SHALL abandon the block; any later core_done_i SHALL be ignored until the FSM reaches WAIT again.
- REQ-036 Release of rst_n SHALL be synchronous to clk, and the first press SHALL be recognized no earlier than 3 edges after release.

Verification
- REQ-037 Scenario 1, load sequence: 32 presses with sw=0..15,0..15 -> core_pt_o=128'h0123456789ABCDEF0123456789ABCDEF; state START.
- REQ-038 Scenario 2, start handshake: core_ready_i=0 for 10 cycles, then 1 -> core_start_o exactly one pulse, on the first ready cycle; busy_o=1.
- REQ-039 Scenario 3, capture and display: core_done_i with ct=128'h69C4E0D86A7B0430D8CDB78070B4C55A -> led=4'h6; after 1 press led=4'h9; done_o high for HOLD_CYCLES=8 cycles exactly.
- REQ-040 Scenario 4, ignored events: presses during WAIT and a core_done_i pulse during LOAD -> no change to idx, pt, ct, or state.
- REQ-041 Scenario 5, wrap: 32 presses in SHOW -> state LOAD, pt=0, led=0; done retrigger on a second capture at count 3 -> done_o extends to 8 more cycles.
- REQ-042 Scenario 6, reset in WAIT: rst_n pulse in WAIT, then core_done_i -> all outputs reset values, state LOAD, ct unchanged at 0.
